lsu_ctrl: RTL and testbench

Load/store initiator between the execute stage and data_mem (word-addressed, 256 x 32, registered read).
- Accepts one load or store request at a time and computes the byte address.
- Checks alignment and funct3, then issues word read/write strobes to memory.
- Sub-word stores use read-modify-write. Load data is byte-extracted and sign/zero-extended.
- Returns a single response with valid/ready handshake.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_ctrl_if.sv | 43 ++++
 rtl/lsu_align.sv | 41 ++++
 rtl/lsu_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 codes and legality helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_ISSUE,
        LD_WAIT,
        RMW_ISSUE,
        RMW_WAIT,
        ST_WRITE,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int WAIT_MAX_DEF = 15;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        return (f3 == F3_B || f3 == F3_H || f3 == F3_W) || (!is_store && (f3 == F3_BU || f3 == F3_HU));
    endfunction

    // Only meaningful for legal codes: f3[1:0] is the access size for both signed and unsigned loads.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        return (f3[1:0] == 2'b01 && lane[0]) || (f3[1:0] == 2'b10 && lane != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request, data-memory and response signals of the load/store unit.
interface lsu_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [2:0]        req_funct3;
    logic [31:0]       req_base;
    logic [31:0]       req_offset;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;
    logic              mem_load;
    logic              mem_store;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic [4:0]        resp_rd;
    logic              resp_is_load;
    logic              resp_err;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
        output req_ready,
        output mem_load, mem_store, mem_addr, mem_wdata,
        input  mem_rdata, mem_rvalid,
        output resp_valid, resp_rdata, resp_rd, resp_is_load, resp_err,
        input  resp_ready
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
        input  req_ready,
        input  mem_load, mem_store, mem_addr, mem_wdata,
        output mem_rdata, mem_rvalid,
        input  resp_valid, resp_rdata, resp_rd, resp_is_load, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: little-endian byte/half extraction with sign/zero extension, and sub-word store lane merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        return f3 == F3_B  ? {{24{b[7]}}, b} :
               f3 == F3_BU ? {24'b0, b} :
               f3 == F3_H  ? {{16{h[15]}}, h} :
               f3 == F3_HU ? {16'b0, h} : w;
    endfunction

    // Bytes outside the written lane(s) keep the value just read from memory.
    function automatic logic [31:0] st_merge(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] old, input logic [31:0] nw);
        logic [31:0] r;
        r = old;
        if (f3 == F3_B)
            r[{a, 3'b000} +: 8] = nw[7:0];
        else if (f3 == F3_H)
            r[{a[1], 4'b0000} +: 16] = nw[15:0];
        else
            r = nw;
        return r;
    endfunction

    assign ld_data = ld_ext(funct3, lane, rdata);
    assign st_data = st_merge(funct3, lane, rdata, wdata);

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: one-at-a-time load/store initiator to a word-addressed, registered-read data memory.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input logic       clk,
    input logic       reset,
    lsu_ctrl_if.slave bus
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_load_q, mem_load_d;
    logic              mem_store_q, mem_store_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [4:0]        resp_rd_q, resp_rd_d;
    logic              resp_is_load_q, resp_is_load_d;
    logic              resp_err_q, resp_err_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       eff_addr, ld_data, st_data;
    logic              bad, unused_hi;

    lsu_align u_align (
        .funct3 (funct3_q),
        .lane   (lane_q),
        .rdata  (bus.mem_rdata),
        .wdata  (wdata_q),
        .ld_data(ld_data),
        .st_data(st_data)
    );

    assign eff_addr  = bus.req_base + bus.req_offset;
    assign unused_hi = ^eff_addr[31:ADDR_W+2];
    assign bad       = !f3_legal(bus.req_is_store, bus.req_funct3) || misaligned(bus.req_funct3, eff_addr[1:0]);

    always_comb begin
        state_d        = state_q;
        mem_load_d     = 1'b0;
        mem_store_d    = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        resp_valid_d   = resp_valid_q;
        resp_rdata_d   = resp_rdata_q;
        resp_rd_d      = resp_rd_q;
        resp_is_load_d = resp_is_load_q;
        resp_err_d     = resp_err_q;
        funct3_d       = funct3_q;
        lane_d         = lane_q;
        wdata_d        = wdata_q;
        cnt_d          = cnt_q;
        case (state_q)
            IDLE: if (bus.req_valid && req_ready_q) begin
                funct3_d       = bus.req_funct3;
                lane_d         = eff_addr[1:0];
                wdata_d        = bus.req_wdata;
                mem_addr_d     = eff_addr[ADDR_W+1:2];
                resp_rd_d      = bus.req_rd;
                resp_is_load_d = !bus.req_is_store;
                resp_err_d     = bad;
                resp_rdata_d   = '0;
                cnt_d          = '0;
                if (bad)
                    state_d = RESP;
                else if (!bus.req_is_store) begin
                    state_d    = LD_ISSUE;
                    mem_load_d = 1'b1;
                end else if (bus.req_funct3 == F3_W) begin
                    state_d     = ST_WRITE;
                    mem_store_d = 1'b1;
                    mem_wdata_d = bus.req_wdata;
                end else begin
                    state_d    = RMW_ISSUE;
                    mem_load_d = 1'b1;
                end
            end
            LD_ISSUE:  state_d = LD_WAIT;
            RMW_ISSUE: state_d = RMW_WAIT;
            LD_WAIT, RMW_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.mem_rvalid && state_q == LD_WAIT) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_data;
                end else if (bus.mem_rvalid) begin
                    state_d     = ST_WRITE;
                    mem_store_d = 1'b1;
                    mem_wdata_d = st_data;
                end else if (cnt_d == CW'(WAIT_MAX)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            // Error requests enter here with resp_valid low and raise it one cycle later.
            RESP: begin
                resp_valid_d = !(resp_valid_q && bus.resp_ready);
                state_d      = (resp_valid_q && bus.resp_ready) ? IDLE : RESP;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = state_d == IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b0;
            mem_load_q     <= 1'b0;
            mem_store_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_rd_q      <= '0;
            resp_is_load_q <= 1'b0;
            resp_err_q     <= 1'b0;
            funct3_q       <= '0;
            lane_q         <= '0;
            wdata_q        <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            mem_load_q     <= mem_load_d;
            mem_store_q    <= mem_store_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_rd_q      <= resp_rd_d;
            resp_is_load_q <= resp_is_load_d;
            resp_err_q     <= resp_err_d;
            funct3_q       <= funct3_d;
            lane_q         <= lane_d;
            wdata_q        <= wdata_d;
            cnt_q          <= cnt_d;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.mem_load     = mem_load_q;
    assign bus.mem_store    = mem_store_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.resp_rd      = resp_rd_q;
    assign bus.resp_is_load = resp_is_load_q;
    assign bus.resp_err     = resp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven directed test of lsu_ctrl against a 256-word registered-read memory model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mute = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lsu_ctrl_if #(.ADDR_W(8)) bus ();

    lsu_ctrl #(.ADDR_W(8), .WAIT_MAX(15)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Memory model: word i holds i, except word 2 = 0x8A000000; reloaded on reset.
    logic [31:0] mem [256];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 2) ? 32'h8A000000 : 32'(i);
            bus.mem_rvalid <= 1'b0;
            bus.mem_rdata  <= '0;
        end else begin
            if (bus.mem_store) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rvalid <= bus.mem_load && !mute;
            bus.mem_rdata  <= mem[bus.mem_addr];
        end
    end

    int          n_load = 0, n_store = 0, proto_bad = 0;
    logic [7:0]  load_addr, store_addr;
    logic [31:0] store_data;
    logic        prev_ld = 1'b0, prev_st = 1'b0;
    always @(negedge clk) begin
        if (bus.mem_load) begin
            n_load++;
            load_addr = bus.mem_addr;
        end
        if (bus.mem_store) begin
            n_store++;
            store_addr = bus.mem_addr;
            store_data = bus.mem_wdata;
        end
        if ((bus.mem_load && bus.mem_store) || (bus.mem_load && prev_ld) || (bus.mem_store && prev_st)) proto_bad++;
        prev_ld = bus.mem_load;
        prev_st = bus.mem_store;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        mute;
        int          hold;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          loads;
        int          stores;
        logic [7:0]  addr;
        logic [31:0] swd;
    } vec_t;

    task automatic run(input vec_t v, input string p);
        int k, lat;
        @(negedge clk);
        mute             = v.mute;
        bus.req_is_store = v.st;
        bus.req_funct3   = v.f3;
        bus.req_base     = v.base;
        bus.req_offset   = v.off;
        bus.req_wdata    = v.wd;
        bus.req_rd       = v.rd;
        bus.req_valid    = 1'b1;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({p, " req_ready"}, 32'(bus.req_ready), 32'd1);
        n_load  = 0;
        n_store = 0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({p, " latency"}, 32'(lat), 32'(v.lat));
        check({p, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
        check({p, " resp_rdata"}, bus.resp_rdata, v.rdata);
        check({p, " resp_err"}, 32'(bus.resp_err), 32'(v.err));
        check({p, " resp_rd"}, 32'(bus.resp_rd), 32'(v.rd));
        check({p, " resp_is_load"}, 32'(bus.resp_is_load), 32'(!v.st));
        check({p, " mem_load count"}, 32'(n_load), 32'(v.loads));
        check({p, " mem_store count"}, 32'(n_store), 32'(v.stores));
        if (v.loads > 0) check({p, " load addr"}, 32'(load_addr), 32'(v.addr));
        if (v.stores > 0) begin
            check({p, " store addr"}, 32'(store_addr), 32'(v.addr));
            check({p, " store data"}, store_data, v.swd);
        end
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            #1;
            check({p, " held valid"}, 32'(bus.resp_valid), 32'd1);
            check({p, " held rdata"}, bus.resp_rdata, v.rdata);
            check({p, " held err"}, 32'(bus.resp_err), 32'(v.err));
            check({p, " held rd"}, 32'(bus.resp_rd), 32'(v.rd));
            check({p, " held req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        check({p, " resp_valid after handshake"}, 32'(bus.resp_valid), 32'd0);
        check({p, " req_ready after handshake"}, 32'(bus.req_ready), 32'd1);
        mute = 1'b0;
    endtask

    vec_t vt[$];
    vec_t lw5;

    initial begin
        int k;
        //           st  f3    base          off           wd            rd     mute hold lat rdata         err ld st addr swd
        vt.push_back('{1'b0, F3_W,  32'h10,       32'h4,        32'h0,        5'd1,  1'b0, 0, 2,  32'h00000005, 1'b0, 1, 0, 8'd5, 32'h0});
        vt.push_back('{1'b0, F3_B,  32'h08,       32'h3,        32'h0,        5'd2,  1'b0, 0, 2,  32'hFFFFFF8A, 1'b0, 1, 0, 8'd2, 32'h0});
        vt.push_back('{1'b0, F3_BU, 32'h08,       32'h3,        32'h0,        5'd3,  1'b0, 0, 2,  32'h0000008A, 1'b0, 1, 0, 8'd2, 32'h0});
        vt.push_back('{1'b1, F3_B,  32'h10,       32'hFFFFFFFD, 32'h000000AB, 5'd4,  1'b0, 0, 3,  32'h0,        1'b0, 1, 1, 8'd3, 32'h0000AB03});
        vt.push_back('{1'b0, F3_W,  32'h06,       32'h0,        32'h0,        5'd5,  1'b0, 0, 1,  32'h0,        1'b1, 0, 0, 8'd0, 32'h0});
        vt.push_back('{1'b0, 3'b011, 32'h08,      32'h0,        32'h0,        5'd6,  1'b0, 0, 1,  32'h0,        1'b1, 0, 0, 8'd0, 32'h0});
        vt.push_back('{1'b1, F3_W,  32'h20,       32'h0,        32'hDEADBEEF, 5'd7,  1'b0, 0, 1,  32'h0,        1'b0, 0, 1, 8'd8, 32'hDEADBEEF});
        vt.push_back('{1'b0, F3_W,  32'h1C,       32'h4,        32'h0,        5'd8,  1'b0, 0, 2,  32'hDEADBEEF, 1'b0, 1, 0, 8'd8, 32'h0});
        vt.push_back('{1'b0, F3_H,  32'h22,       32'h0,        32'h0,        5'd9,  1'b0, 0, 2,  32'hFFFFDEAD, 1'b0, 1, 0, 8'd8, 32'h0});
        vt.push_back('{1'b0, F3_HU, 32'h22,       32'h0,        32'h0,        5'd10, 1'b0, 0, 2,  32'h0000DEAD, 1'b0, 1, 0, 8'd8, 32'h0});
        vt.push_back('{1'b1, F3_H,  32'h22,       32'h0,        32'hFFFF1234, 5'd11, 1'b0, 0, 3,  32'h0,        1'b0, 1, 1, 8'd8, 32'h1234BEEF});
        vt.push_back('{1'b0, F3_B,  32'h21,       32'h0,        32'h0,        5'd12, 1'b0, 0, 2,  32'hFFFFFFBE, 1'b0, 1, 0, 8'd8, 32'h0});
        vt.push_back('{1'b0, F3_B,  32'h23,       32'h0,        32'h0,        5'd13, 1'b0, 0, 2,  32'h00000012, 1'b0, 1, 0, 8'd8, 32'h0});
        vt.push_back('{1'b0, F3_H,  32'h21,       32'h0,        32'h0,        5'd14, 1'b0, 0, 1,  32'h0,        1'b1, 0, 0, 8'd0, 32'h0});
        vt.push_back('{1'b1, 3'b100, 32'h10,      32'h0,        32'h55,       5'd15, 1'b0, 0, 1,  32'h0,        1'b1, 0, 0, 8'd0, 32'h0});
        vt.push_back('{1'b1, F3_W,  32'h22,       32'h0,        32'h77,       5'd16, 1'b0, 0, 1,  32'h0,        1'b1, 0, 0, 8'd0, 32'h0});
        vt.push_back('{1'b0, F3_W,  32'hFFFFFFFC, 32'h18,       32'h0,        5'd17, 1'b0, 0, 2,  32'h00000005, 1'b0, 1, 0, 8'd5, 32'h0});
        vt.push_back('{1'b0, F3_W,  32'h400,      32'h14,       32'h0,        5'd18, 1'b0, 0, 2,  32'h00000005, 1'b0, 1, 0, 8'd5, 32'h0});
        vt.push_back('{1'b0, F3_W,  32'h14,       32'h0,        32'h0,        5'd19, 1'b1, 3, 16, 32'h0,        1'b1, 1, 0, 8'd5, 32'h0});
        vt.push_back('{1'b1, F3_B,  32'h0C,       32'h0,        32'hEE,       5'd20, 1'b1, 0, 16, 32'h0,        1'b1, 1, 0, 8'd3, 32'h0});
        vt.push_back('{1'b0, F3_W,  32'h0C,       32'h0,        32'h0,        5'd21, 1'b0, 0, 2,  32'h0000AB03, 1'b0, 1, 0, 8'd3, 32'h0});
        lw5 = '{1'b0, F3_W, 32'h14, 32'h0, 32'h0, 5'd22, 1'b0, 0, 2, 32'h00000005, 1'b0, 1, 0, 8'd5, 32'h0};

        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = '0;
        bus.req_base     = '0;
        bus.req_offset   = '0;
        bus.req_wdata    = '0;
        bus.req_rd       = '0;
        bus.resp_ready   = 1'b0;

        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(bus.req_ready), 32'd0);
        check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset mem_load", 32'(bus.mem_load), 32'd0);
        check("reset mem_store", 32'(bus.mem_store), 32'd0);
        check("reset mem_addr", 32'(bus.mem_addr), 32'd0);
        check("reset resp_rdata", bus.resp_rdata, 32'd0);
        reset = 1'b0;

        foreach (vt[i]) run(vt[i], $sformatf("v%0d", i));

        // Reset while a sub-word store is waiting on its read.
        @(negedge clk);
        mute             = 1'b1;
        bus.req_is_store = 1'b1;
        bus.req_funct3   = F3_B;
        bus.req_base     = 32'h0D;
        bus.req_offset   = 32'h0;
        bus.req_wdata    = 32'hCD;
        bus.req_rd       = 5'd23;
        bus.req_valid    = 1'b1;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
        n_load  = 0;
        n_store = 0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst mem_load", 32'(bus.mem_load), 32'd0);
        check("rst mem_store", 32'(bus.mem_store), 32'd0);
        check("rst mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst mem_wdata", bus.mem_wdata, 32'd0);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst req_ready", 32'(bus.req_ready), 32'd0);
        check("rst resp_err", 32'(bus.resp_err), 32'd0);
        repeat (3) @(negedge clk);
        mute  = 1'b0;
        reset = 1'b0;
        check("rst mem_store count", 32'(n_store), 32'd0);
        check("rst mem_load count", 32'(n_load), 32'd1);
        run(lw5, "post-reset lw");

        check("strobe protocol violations", 32'(proto_bad), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
